if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/pc_reg.sv | 48 ++++
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
//------------------------------------------------------------------------------
// Module : if_stage_pkg
// Brief  : Shared pipeline constants and fetch-FSM state encoding.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package if_stage_pkg;

   localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] c_NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } if_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
//------------------------------------------------------------------------------
// Module : pc_reg
// Brief  : Fetch program counter with redirect / hold / increment next-PC mux.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic        hold,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;

   assign pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_pc_next = pc_plus4;
      if (redirect)
         w_pc_next = redirect_pc & c_ALIGN_MASK;
      else if (hold)
         w_pc_next = r_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pc <= RESET_PC;
      else
         r_pc <= w_pc_next;
   end

   assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// Module : if_stage
// Brief  : Instruction fetch stage: PC, IF/ID register, fetch FSM and counter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_RESET_PC,
   parameter logic [31:0] NOP      = c_NOP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] inst_i,
   output logic [13:0] irom_addr_o,
   output logic [31:0] pc_o,
   output logic [31:0] id_inst_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc4_o,
   output logic        id_valid_o,
   output logic        flush_o,
   output logic [31:0] fetch_cnt_o
);

   if_state_e   r_state;
   if_state_e   w_state_next;
   logic        w_boot;
   logic        w_capture;
   logic [31:0] w_pc_plus4;
   logic [31:0] r_id_inst;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_pc4;
   logic        r_id_valid;
   logic [31:0] r_fetch_cnt;

   assign w_boot    = (r_state == ST_BOOT);
   assign w_capture = !redirect && !stall && !w_boot;

   // The PC must not advance in BOOT, otherwise the RESET_PC instruction is skipped.
   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .hold        (stall || w_boot),
      .redirect_pc (redirect_pc),
      .pc          (pc_o),
      .pc_plus4    (w_pc_plus4)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_BOOT: w_state_next = (stall && !redirect) ? ST_HOLD : ST_RUN;
         ST_RUN:  w_state_next = (stall && !redirect) ? ST_HOLD : ST_RUN;
         ST_HOLD: w_state_next = (!stall || redirect) ? ST_RUN  : ST_HOLD;
         default: w_state_next = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_BOOT;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id_inst  <= NOP;
         r_id_pc    <= 32'd0;
         r_id_pc4   <= 32'd0;
         r_id_valid <= 1'b0;
      end else if (redirect) begin
         r_id_inst  <= NOP;
         r_id_pc    <= 32'd0;
         r_id_pc4   <= 32'd0;
         r_id_valid <= 1'b0;
      end else if (stall) begin
         r_id_inst  <= r_id_inst;
         r_id_pc    <= r_id_pc;
         r_id_pc4   <= r_id_pc4;
         r_id_valid <= r_id_valid;
      end else if (w_boot) begin
         r_id_inst  <= NOP;
         r_id_pc    <= 32'd0;
         r_id_pc4   <= 32'd0;
         r_id_valid <= 1'b0;
      end else begin
         r_id_inst  <= inst_i;
         r_id_pc    <= pc_o;
         r_id_pc4   <= w_pc_plus4;
         r_id_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_fetch_cnt <= 32'd0;
      else if (w_capture)
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
   end

   assign irom_addr_o = pc_o[15:2];
   assign flush_o     = redirect;
   assign id_inst_o   = r_id_inst;
   assign id_pc_o     = r_id_pc;
   assign id_pc4_o    = r_id_pc4;
   assign id_valid_o  = r_id_valid;
   assign fetch_cnt_o = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//------------------------------------------------------------------------------
// Module : tb_if_stage
// Brief  : Self-checking directed bench for if_stage.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_stage;
   import if_stage_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] inst_i;
   logic [13:0] irom_addr_o;
   logic [31:0] pc_o;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc4_o;
   logic        id_valid_o;
   logic        flush_o;
   logic [31:0] fetch_cnt_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] ipc;
      logic [31:0] ipc4;
      logic        valid;
      logic [31:0] cnt;
      logic [1:0]  st;
   } vec_t;

   vec_t vecs [15];

   if_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_i      (inst_i),
      .irom_addr_o (irom_addr_o),
      .pc_o        (pc_o),
      .id_inst_o   (id_inst_o),
      .id_pc_o     (id_pc_o),
      .id_pc4_o    (id_pc4_o),
      .id_valid_o  (id_valid_o),
      .flush_o     (flush_o),
      .fetch_cnt_o (fetch_cnt_o)
   );

   // ROM contents tag each word with its own word address.
   assign inst_i = 32'hA000_0000 | {18'd0, irom_addr_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " pc"},    pc_o,               32'h0);
      check({tag, " inst"},  id_inst_o,          32'h0000_0013);
      check({tag, " idpc"},  id_pc_o,            32'h0);
      check({tag, " idpc4"}, id_pc4_o,           32'h0);
      check({tag, " valid"}, {31'd0, id_valid_o}, 32'h0);
      check({tag, " cnt"},   fetch_cnt_o,        32'h0);
      check({tag, " state"}, {30'd0, dut.r_state}, {30'd0, ST_BOOT});
   endtask

   initial begin
      //            stall redir rpc            pc             inst           idpc           idpc4          v     cnt  state
      vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0013, 32'h0,         32'h0,         1'b0, 32'd0, ST_RUN};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'hA000_0000, 32'h0,         32'h4,         1'b1, 32'd1, ST_RUN};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h8,         32'hA000_0001, 32'h4,         32'h8,         1'b1, 32'd2, ST_RUN};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,         32'hC,         32'hA000_0002, 32'h8,         32'hC,         1'b1, 32'd3, ST_RUN};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'h10,        32'hA000_0003, 32'hC,         32'h10,        1'b1, 32'd4, ST_RUN};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,         32'h10,        32'hA000_0003, 32'hC,         32'h10,        1'b1, 32'd4, ST_HOLD};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,         32'h10,        32'hA000_0003, 32'hC,         32'h10,        1'b1, 32'd4, ST_HOLD};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h14,        32'hA000_0004, 32'h10,        32'h14,        1'b1, 32'd5, ST_RUN};
      vecs[8]  = '{1'b0, 1'b1, 32'h103,       32'h100,       32'h0000_0013, 32'h0,         32'h0,         1'b0, 32'd5, ST_RUN};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,         32'h104,       32'hA000_0040, 32'h100,       32'h104,       1'b1, 32'd6, ST_RUN};
      vecs[10] = '{1'b1, 1'b1, 32'h40,        32'h40,        32'h0000_0013, 32'h0,         32'h0,         1'b0, 32'd6, ST_RUN};
      vecs[11] = '{1'b1, 1'b0, 32'h0,         32'h40,        32'h0000_0013, 32'h0,         32'h0,         1'b0, 32'd6, ST_HOLD};
      vecs[12] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0,         32'h0,         1'b0, 32'd6, ST_RUN};
      vecs[13] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'hA000_3FFF, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'd7, ST_RUN};
      vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'hA000_0000, 32'h0,         32'h4,         1'b1, 32'd8, ST_RUN};

      rst_n       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i != 0) @(negedge clk);
         stall       = vecs[i].stall;
         redirect    = vecs[i].redirect;
         redirect_pc = vecs[i].rpc;
         #1;
         check($sformatf("v%0d flush", i), {31'd0, flush_o}, {31'd0, vecs[i].redirect});
         @(posedge clk);
         #1;
         check($sformatf("v%0d pc", i),    pc_o,        vecs[i].pc);
         check($sformatf("v%0d irom", i),  {18'd0, irom_addr_o}, {18'd0, vecs[i].pc[15:2]});
         check($sformatf("v%0d inst", i),  id_inst_o,   vecs[i].inst);
         check($sformatf("v%0d idpc", i),  id_pc_o,     vecs[i].ipc);
         check($sformatf("v%0d idpc4", i), id_pc4_o,    vecs[i].ipc4);
         check($sformatf("v%0d valid", i), {31'd0, id_valid_o}, {31'd0, vecs[i].valid});
         check($sformatf("v%0d cnt", i),   fetch_cnt_o, vecs[i].cnt);
         check($sformatf("v%0d state", i), {30'd0, dut.r_state}, {30'd0, vecs[i].st});
      end

      // Asynchronous reset in the middle of a HOLD with a redirect pending.
      @(negedge clk);
      stall = 1'b1;
      @(posedge clk);
      #1;
      check("hold state", {30'd0, dut.r_state}, {30'd0, ST_HOLD});
      #2;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      rst_n       = 1'b0;
      #1;
      check_reset_values("async");

      // Release while stalled: BOOT goes to HOLD and the PC stays put.
      @(negedge clk);
      redirect = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      check("boot stall pc",    pc_o, 32'h0);
      check("boot stall valid", {31'd0, id_valid_o}, 32'h0);
      check("boot stall state", {30'd0, dut.r_state}, {30'd0, ST_HOLD});
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      check("post boot pc",    pc_o,        32'h4);
      check("post boot inst",  id_inst_o,   32'hA000_0000);
      check("post boot valid", {31'd0, id_valid_o}, 32'h1);
      check("post boot cnt",   fetch_cnt_o, 32'd1);
      check("post boot state", {30'd0, dut.r_state}, {30'd0, ST_RUN});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
